// File: rtl/wb_arbiter_pkg.sv
// Shared types and helpers for the writeback arbiter slice.
package wb_arbiter_pkg;

    localparam int unsigned WIDTH      = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [WIDTH-1:0]      data;
    } lu_entry_t;

    // Writeback result mux; the unused encoding 2'b11 falls back to the ALU result.
    function automatic logic [WIDTH-1:0] wb_select(
        input logic [1:0]       sel,
        input logic [WIDTH-1:0] alu,
        input logic [WIDTH-1:0] load,
        input logic [WIDTH-1:0] pc4
    );
        case (sel)
            WB_MEM:  return load;
            WB_PC4:  return pc4;
            default: return alu;
        endcase
    endfunction

endpackage

// File: rtl/wb_lu_fifo.sv
// Small synchronous FIFO buffering long-latency unit results.
module wb_lu_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  lu_entry_t push_entry,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output lu_entry_t head
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    lu_entry_t       mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is a power of 2).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/wb_arbiter.sv
// MEM/WB register, writeback mux and register-file write-port arbitration
// between the in-order pipeline and a buffered long-latency unit.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned LU_DEPTH     = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_valid,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd_addr,
    input  logic [1:0]            mem_wb_sel,
    input  logic [WIDTH-1:0]      mem_alu_result,
    input  logic [WIDTH-1:0]      mem_load_data,
    input  logic [WIDTH-1:0]      mem_pc_plus4,
    input  logic                  lu_valid,
    output logic                  lu_ready,
    input  logic [REG_ADDR_W-1:0] lu_rd_addr,
    input  logic [WIDTH-1:0]      lu_data,
    output logic                  stall_req,
    output logic                  wr_en,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  wb_src_lu
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic                  wb_valid;
    logic                  wb_reg_write;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [1:0]            wb_sel;
    logic [WIDTH-1:0]      wb_alu;
    logic [WIDTH-1:0]      wb_load;
    logic [WIDTH-1:0]      wb_pc4;

    logic                  pipe_wr;
    logic [WIDTH-1:0]      pipe_data;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    lu_entry_t             fifo_head;
    lu_entry_t             fifo_in;

    logic [SW-1:0]         starve_cnt;
    logic                  starve_hit;

    // MEM/WB pipeline register; a stall injects a bubble while upstream holds its contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= '0;
            wb_sel       <= '0;
            wb_alu       <= '0;
            wb_load      <= '0;
            wb_pc4       <= '0;
        end else if (stall_req) begin
            wb_valid     <= 1'b0;
        end else begin
            wb_valid     <= mem_valid;
            wb_reg_write <= mem_reg_write;
            wb_rd        <= mem_rd_addr;
            wb_sel       <= mem_wb_sel;
            wb_alu       <= mem_alu_result;
            wb_load      <= mem_load_data;
            wb_pc4       <= mem_pc_plus4;
        end
    end

    assign pipe_wr   = wb_valid & wb_reg_write & (wb_rd != '0);
    assign pipe_data = wb_select(wb_sel, wb_alu, wb_load, wb_pc4);

    // No pass-through when full: readiness comes from registered occupancy only.
    assign lu_ready     = ~fifo_full;
    assign fifo_push    = lu_valid & lu_ready;
    assign fifo_in.rd   = lu_rd_addr;
    assign fifo_in.data = lu_data;

    wb_lu_fifo #(
        .DEPTH (LU_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_entry (fifo_in),
        .pop        (fifo_pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (fifo_head)
    );

    // Write-port arbitration: pipeline has priority, FIFO drains in bubbles; rd=0 heads are dropped.
    always_comb begin
        wr_en     = 1'b0;
        rd_addr   = '0;
        rd_data   = '0;
        wb_src_lu = 1'b0;
        fifo_pop  = 1'b0;
        if (pipe_wr) begin
            wr_en   = 1'b1;
            rd_addr = wb_rd;
            rd_data = pipe_data;
        end else if (!fifo_empty) begin
            wr_en     = (fifo_head.rd != '0);
            rd_addr   = fifo_head.rd;
            rd_data   = fifo_head.data;
            wb_src_lu = 1'b1;
            fifo_pop  = 1'b1;
        end
    end

    assign starve_hit = (starve_cnt == SW'(STARVE_LIMIT));

    // Starvation guard: count full-without-pop cycles, then request a single-cycle stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else begin
            stall_req <= starve_hit;
            if (starve_hit || fifo_pop) begin
                starve_cnt <= '0;
            end else if (fifo_full) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback-side owner of the register file write port (wr_en, rd_addr, rd_data) in the pipelined core.
- Holds the MEM/WB pipeline register, selects the writeback result (ALU / load / PC+4) and arbitrates the single write port between the in-order pipeline and a long-latency unit (mul/div).
- Long-latency results are buffered in a small FIFO and drained in pipeline bubbles. A starvation guard requests a one-cycle pipeline stall when the FIFO cannot drain.

Parameters:
- LU_DEPTH, 2, long-latency result FIFO depth (power of 2, >=2).
- STARVE_LIMIT, 4, consecutive cycles the FIFO may stay full without a pop before stall_req is raised.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- mem_valid  in  1  MEM stage holds a valid instruction
- mem_reg_write  in  1  instruction writes rd
- mem_rd_addr  in  5  destination register
- mem_wb_sel  in  2  wb_sel_t: WB_ALU, WB_MEM, WB_PC4
- mem_alu_result  in  WIDTH  ALU result
- mem_load_data  in  WIDTH  load data, already aligned and extended
- mem_pc_plus4  in  WIDTH  link value
- lu_valid  in  1  long-latency result offered
- lu_ready  out  1  FIFO can accept a result
- lu_rd_addr  in  5  long-latency destination register
- lu_data  in  WIDTH  long-latency result
- stall_req  out  1  upstream must hold MEM-stage contents this cycle
- wr_en  out  1  register file write enable
- rd_addr  out  5  register file write address
- rd_data  out  WIDTH  register file write data
- wb_src_lu  out  1  current write comes from the FIFO (for hazard and forwarding logic)

Behaviour:
- Reset (clk edge with rst=1): MEM/WB register cleared (valid=0), FIFO emptied, starvation counter=0, stall_req=0. Resulting outputs: wr_en=0, rd_addr=0, rd_data=0, wb_src_lu=0, lu_ready=1. rst mid-operation discards FIFO contents and any in-flight writeback.
- MEM/WB register: captures all mem_* fields on each clk edge when stall_req=0. When stall_req=1 it loads a bubble (valid=0) and mem_* are ignored; upstream holds them and re-presents them next cycle.
- Pipe result data:
  - WB_ALU selects alu_result, WB_MEM selects load_data, WB_PC4 selects pc_plus4.
  - Encoding 2'b11 selects alu_result.
- pipe_wr = wb_valid & wb_reg_write & (wb_rd != 0).
- Port arbitration is combinational from registered state, so the regfile writes on the next edge:
  - If pipe_wr: wr_en=1, rd_addr/rd_data from the pipe, wb_src_lu=0, no FIFO pop.
  - Else if FIFO is non-empty: wr_en = (head.rd != 0), rd_addr/rd_data from the head, wb_src_lu=1, pop.
  - A head entry with rd=0 is popped without a write.
  - Else: wr_en=0; rd_addr, rd_data and wb_src_lu are 0.
- FIFO:
  - lu_ready = (count != LU_DEPTH), derived from registered count only. There is no pass-through when full, even if a pop occurs in the same cycle.
  - Push on lu_valid & lu_ready. Minimum latency from lu handshake to wr_en is 1 cycle.
  - Simultaneous push and pop: count unchanged, ordering preserved.
  - Pointers wrap modulo LU_DEPTH.
- Starvation guard:
  - The counter increments each cycle the FIFO is full and no pop occurs. It saturates at STARVE_LIMIT and clears on any pop.
  - stall_req is registered. It is set for exactly one cycle on the edge after the counter reaches STARVE_LIMIT, then cleared and the counter reset.
  - The forced bubble guarantees one pop.
- Write-after-write ordering between pipe and FIFO to the same rd is not resolved here. The hazard unit prevents issuing a pipe instruction to a register with an outstanding long-latency write.

Decomposition:
- all_pkgs holds: WIDTH, REG_ADDR_W=5, wb_sel_t enum, lu_entry_t struct {rd, data}.
- One sub-module: wb_lu_fifo (parameterised synchronous FIFO; push/pop/full/empty/head).

Test Plan:
- Reset: assert rst 2 cycles with lu_valid=1 -> wr_en=0, lu_ready=1, stall_req=0; no push occurs.
- Pipe writeback: mem_valid=1, reg_write=1, rd=5, wb_sel=WB_MEM, load_data=0xDEADBEEF -> next cycle wr_en=1, rd_addr=5, rd_data=0xDEADBEEF, wb_src_lu=0.
- Writes to x0 and bubbles: pipe rd=0 with FIFO holding {rd=7, 0x1234} -> FIFO entry written (wr_en=1, rd_addr=7, wb_src_lu=1); a FIFO entry with rd=0 is popped with wr_en=0.
- Contention: continuous pipe writes with lu results to rd=9 then rd=10 -> FIFO fills, lu_ready=0 while count=2; after 4 full cycles stall_req=1 for one cycle; the next cycle writes rd=9, then 10 on the next bubble, in order.
- Simultaneous push/pop: FIFO count=1 and a bubble coincide with an lu handshake -> count stays 1, head advances; pointer wrap verified over 10 entries with data 0..9 written in order.
- Reset mid-operation: FIFO full and stall_req pending, rst=1 -> FIFO empty, stall_req=0, wr_en=0 on the next cycle; no stale write afterwards.
